wb_s15_responder: RTL and testbench

Wishbone-classic slave responder for interconnect slave port 15. It sits at the far end of the m0→s15 path. It accepts master write data and addresses, holds a small register bank, and drives the s15 read data that flows back toward the master through the slave-15 data-output tap. It adds a programmable wait-state count, error signalling, and a read-only ID word, so the bench has a real, cycle-accurate slave to exercise the data path against.

---
 rtl/wb_s15_responder_if.sv | 25 ++
 rtl/wb_s15_responder.sv | 96 +++++++++
 tb/tb_wb_s15_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_s15_responder_if.sv
// rtl/wb_s15_responder_if.sv - Wishbone-classic bus bundle for interconnect slave port 15.
interface wb_s15_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      s15_cyc_i;
  logic                      s15_stb_i;
  logic                      s15_we_i;
  logic [ADDR_WIDTH-1:0]     s15_adr_i;
  logic [DATA_WIDTH/8-1:0]   s15_sel_i;
  logic [DATA_WIDTH-1:0]     s15_data_i;
  logic [DATA_WIDTH-1:0]     s15_data_o;
  logic                      s15_ack_o;
  logic                      s15_err_o;

  modport slave (
    input  s15_cyc_i, s15_stb_i, s15_we_i, s15_adr_i, s15_sel_i, s15_data_i,
    output s15_data_o, s15_ack_o, s15_err_o
  );

  modport master (
    output s15_cyc_i, s15_stb_i, s15_we_i, s15_adr_i, s15_sel_i, s15_data_i,
    input  s15_data_o, s15_ack_o, s15_err_o
  );
endinterface

// File: rtl/wb_s15_responder.sv
// rtl/wb_s15_responder.sv - Wishbone-classic slave for port 15: register bank, wait states,
// error termination and a read-only ID word in the top register.
module wb_s15_responder #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    REG_COUNT   = 16,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h51500F0F
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  wb_s15_responder_if.slave    s15
);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam state_t ST_AFTER_REQ = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  r_we;
  logic [LANES-1:0]      r_sel;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  logic                  w_req;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_dec_err;
  logic                  w_is_id;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_req     = s15.s15_cyc_i & s15.s15_stb_i;
  assign w_idx     = r_adr[IDX_W+1:2];
  // Misaligned or beyond the bank both terminate with err.
  assign w_dec_err = (r_adr[1:0] != 2'b00) | (|r_adr[ADDR_WIDTH-1:IDX_W+2]);
  assign w_is_id   = (w_idx == IDX_W'(REG_COUNT - 1));
  assign w_wr_en   = (r_state == ST_RESP) & r_we & ~w_dec_err & ~w_is_id;
  assign w_rd_word = w_is_id ? ID_VALUE : r_regs[w_idx];

  always_comb begin
    w_next         = r_state;
    s15.s15_ack_o  = 1'b0;
    s15.s15_err_o  = 1'b0;
    s15.s15_data_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_next = ST_AFTER_REQ;
      end
      ST_WAIT: begin
        if (!s15.s15_cyc_i)   w_next = ST_IDLE;
        else if (r_cnt == '0) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_next        = ST_IDLE;
        s15.s15_ack_o = ~w_dec_err;
        s15.s15_err_o = w_dec_err;
        if (!w_dec_err && !r_we) s15.s15_data_o = w_rd_word;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_req) begin
        r_adr   <= s15.s15_adr_i;
        r_we    <= s15.s15_we_i;
        r_sel   <= s15.s15_sel_i;
        r_wdata <= s15.s15_data_i;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_wr_en) begin
        for (int k = 0; k < LANES; k++) begin
          if (r_sel[k]) r_regs[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_s15_responder.sv
// tb/tb_wb_s15_responder.sv - Scoreboard bench for wb_s15_responder, three instances with
// WAIT_STATES of 1, 3 and 0.
module tb_wb_s15_responder;
  localparam logic [31:0] ID = 32'h51500F0F;

  typedef struct {
    int          inst;
    logic        err;
    logic [31:0] data;
  } sb_t;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  cyc, stb, we;
  logic [31:0] adr  [3];
  logic [3:0]  sel  [3];
  logic [31:0] wdat [3];
  logic [2:0]  ack, err;
  logic [31:0] rdata [3];

  logic [31:0] mdl [3][16];
  sb_t         sb [$];
  sb_t         e;
  int          n_checks = 0;
  int          n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    wb_s15_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    assign bus.s15_cyc_i  = cyc[g];
    assign bus.s15_stb_i  = stb[g];
    assign bus.s15_we_i   = we[g];
    assign bus.s15_adr_i  = adr[g];
    assign bus.s15_sel_i  = sel[g];
    assign bus.s15_data_i = wdat[g];
    assign ack[g]   = bus.s15_ack_o;
    assign err[g]   = bus.s15_err_o;
    assign rdata[g] = bus.s15_data_o;
    wb_s15_responder #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_COUNT(16),
      .WAIT_STATES(WS), .ID_VALUE(ID)
    ) u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n[g]),
      .s15     (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 1 : ((inst == 1) ? 3 : 0);
  endfunction

  // Reference model: returns expected response and applies acked writes.
  task automatic model_xfer(input int inst, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    sb_t         x;
    logic [3:0]  idx;
    idx    = a[5:2];
    x.inst = inst;
    x.err  = (a[1:0] != 2'b00) || (a >= 32'd64);
    x.data = 32'h0;
    if (!x.err && !w) x.data = (idx == 4'd15) ? ID : mdl[inst][idx];
    if (!x.err && w && idx != 4'd15)
      for (int k = 0; k < 4; k++) if (s[k]) mdl[inst][idx][8*k +: 8] = d[8*k +: 8];
    sb.push_back(x);
  endtask

  task automatic clear_model(input int inst);
    for (int i = 0; i < 16; i++) mdl[inst][i] = 32'h0;
  endtask

  task automatic drive(input int inst, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    cyc[inst] = 1'b1; stb[inst] = 1'b1; we[inst] = w;
    adr[inst] = a; wdat[inst] = d; sel[inst] = s;
  endtask

  task automatic release_bus(input int inst);
    cyc[inst] = 1'b0; stb[inst] = 1'b0;
  endtask

  // Call just after a falling edge with the DUT idle; returns just after a falling edge, idle.
  task automatic do_xfer(input int inst, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    int cyc_n;
    bit done;
    model_xfer(inst, w, a, d, s);
    drive(inst, w, a, d, s);
    @(posedge clk);
    cyc_n = 0;
    done  = 0;
    while (!done && cyc_n < 20) begin
      @(negedge clk);
      if (ack[inst] || err[inst]) done = 1;
      else cyc_n++;
    end
    check("latency", cyc_n, ws_of(inst));
    release_bus(inst);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ack[g] && err[g]) check("ack_and_err", 1, 0);
      if (ack[g] || err[g]) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", {30'h0, ack[g], err[g]}, 0);
        end else begin
          e = sb.pop_front();
          check("resp_inst", g, e.inst);
          check("resp_ack", ack[g], !e.err);
          check("resp_err", err[g], e.err);
          check("resp_data", rdata[g], e.data);
        end
      end else begin
        check("idle_data", rdata[g], 32'h0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit done;
    rst_n = 3'b000; cyc = 3'b000; stb = 3'b000; we = 3'b000;
    for (int i = 0; i < 3; i++) begin
      adr[i] = 32'h0; sel[i] = 4'h0; wdat[i] = 32'h0;
      clear_model(i);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", ack[i], 0);
      check("rst_err", err[i], 0);
      check("rst_data", rdata[i], 0);
    end
    rst_n = 3'b111;
    @(negedge clk);

    // Basic write/read, byte lanes, errors, ID register (WAIT_STATES=1)
    do_xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF);
    do_xfer(0, 0, 32'h04, 32'h0, 4'hF);
    do_xfer(0, 1, 32'h08, 32'h11223344, 4'hF);
    do_xfer(0, 1, 32'h08, 32'hAABBCCDD, 4'b0101);
    do_xfer(0, 0, 32'h08, 32'h0, 4'hF);
    check("lane_model", mdl[0][2], 32'h11BB33DD);
    do_xfer(0, 0, 32'h40, 32'h0, 4'hF);
    do_xfer(0, 1, 32'h06, 32'h55555555, 4'hF);
    do_xfer(0, 0, 32'h04, 32'h0, 4'hF);
    do_xfer(0, 0, 32'h3C, 32'h0, 4'hF);
    do_xfer(0, 1, 32'h3C, 32'h0, 4'hF);
    do_xfer(0, 0, 32'h3C, 32'h0, 4'hF);
    do_xfer(0, 1, 32'h04, 32'h00000000, 4'h0);
    do_xfer(0, 0, 32'h04, 32'h0, 4'hF);
    do_xfer(0, 0, 32'h8000_0004, 32'h0, 4'hF);

    // Abort in the 2nd wait cycle (WAIT_STATES=3)
    do_xfer(1, 1, 32'h0C, 32'h12345678, 4'hF);
    drive(1, 1, 32'h0C, 32'hCAFEF00D, 4'hF);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    release_bus(1);
    repeat (6) @(negedge clk);
    do_xfer(1, 0, 32'h0C, 32'h0, 4'hF);

    // Reset during the response cycle clears outputs at once
    model_xfer(1, 0, 32'h3C, 32'h0, 4'hF);
    drive(1, 0, 32'h3C, 32'h0, 4'hF);
    @(posedge clk);
    n = 0; done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (ack[1] || err[1]) done = 1; else n++;
    end
    check("rst_resp_latency", n, 3);
    #2 rst_n[1] = 1'b0;
    #1;
    check("rst_resp_ack", ack[1], 0);
    check("rst_resp_data", rdata[1], 0);
    release_bus(1);
    clear_model(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Reset mid-WAIT drops the pending write
    drive(1, 1, 32'h10, 32'hFFFFFFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("rst_wait_ack", ack[1], 0);
    check("rst_wait_err", err[1], 0);
    check("rst_wait_data", rdata[1], 0);
    release_bus(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    do_xfer(1, 0, 32'h10, 32'h0, 4'hF);
    do_xfer(1, 0, 32'h0C, 32'h0, 4'hF);
    do_xfer(1, 1, 32'h14, 32'h0BADF00D, 4'hF);
    do_xfer(1, 0, 32'h14, 32'h0, 4'hF);

    // Back-to-back reads with stb held (WAIT_STATES=0)
    do_xfer(2, 1, 32'h00, 32'hA0A0A0A0, 4'hF);
    do_xfer(2, 1, 32'h04, 32'hB1B1B1B1, 4'hF);
    do_xfer(2, 1, 32'h08, 32'hC2C2C2C2, 4'hF);
    for (int i = 0; i < 3; i++) model_xfer(2, 0, 32'(i * 4), 32'h0, 4'hF);
    drive(2, 0, 32'h00, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_ack", ack[2], 1);
      if (i < 2) adr[2] = 32'((i + 1) * 4);
      @(posedge clk);
      @(negedge clk);
      check("b2b_gap", ack[2], 0);
    end
    release_bus(2);
    @(negedge clk);

    // Random traffic over all instances
    for (int i = 0; i < 30; i++) begin
      int          inst;
      logic [31:0] a;
      inst = int'($urandom_range(0, 2));
      a    = 32'($urandom_range(0, 17)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'd2;
      do_xfer(inst, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) do_xfer(0, 0, 32'(i * 4), 32'h0, 4'hF);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
